menu_nav_ctrl: RTL and testbench
================================

# menu_nav_ctrl

Parametrised key-driven menu navigation controller for the front panel: it consumes one-cycle release pulses from the six key debouncers and maintains the top-level menu selection, a per-submenu field cursor, and a bank of editable field values. On an explicit apply it commits the edited values to a registered configuration bus for the downstream function blocks (signal generator, oscilloscope, analyser). Compared with the current fixed three-item controller, item count, field count and value range are parameters. The block adds explicit priority, an apply row, a run level and a one-cycle apply strobe.

## Interface
- N_MENU, 3: number of top-level menu items (≥2)
- N_FIELD, 4: editable fields per submenu (≥1); cursor index N_FIELD is the apply row
- VAL_W, 2: width of each field value
- VAL_MAX, 3: largest field value (≤ 2^VAL_W−1); values wrap 0..VAL_MAX
- Derived: MSEL_W = max(1,clog2(N_MENU)); FSEL_W = clog2(N_FIELD+1)
- clk_50M  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous active-low reset
- key_left, key_right, key_up, key_down, key_confirm, key_quit  in  1 each  one-cycle release pulses from debouncers
- level  out  2  0=TOP, 1=EDIT, 2=RUN
- menu_sel  out  MSEL_W  highlighted or entered menu item
- menu_act  out  N_MENU  one-hot of menu_sel while level≠TOP, else 0
- field_sel  out  FSEL_W  field cursor, 0..N_FIELD
- edit_vals  out  N_FIELD*VAL_W  edit bank; field i at [i*VAL_W +: VAL_W]
- cfg_out  out  N_FIELD*VAL_W  committed configuration, same packing
- cfg_valid  out  1  high while cfg_out holds a committed configuration
- apply_stb  out  1  one-cycle pulse on commit

## Operation
- All outputs are registered. Reset values: level=0, menu_sel=0, menu_act=0, field_sel=0, edit_vals=0, cfg_out=0, cfg_valid=0, apply_stb=0.
- At most one key action is taken per cycle. Priority: quit > confirm > up > down > left > right. Lower-priority pulses in the same cycle are discarded, not queued.
- TOP:
  - left: menu_sel−1, wrapping 0→N_MENU−1.
  - right: menu_sel+1, wrapping N_MENU−1→0.
  - confirm: go to EDIT with field_sel=0.
  - up, down, quit: no effect.
- EDIT:
  - up: field_sel−1, wrapping 0→N_FIELD.
  - down: field_sel+1, wrapping N_FIELD→0.
  - left/right with field_sel<N_FIELD: decrement/increment that field, wrapping 0↔VAL_MAX. Other fields are unchanged.
  - left/right with field_sel=N_FIELD: no effect.
  - confirm with field_sel=N_FIELD: cfg_out←edit_vals, cfg_valid←1, apply_stb=1 for one cycle, go to RUN.
  - confirm elsewhere: no effect.
  - quit: go to TOP. Clears field_sel, edit_vals, cfg_out and cfg_valid. menu_sel is retained.
- RUN:
  - quit: go to EDIT. field_sel and edit_vals are retained. cfg_out and cfg_valid stay held.
  - All other keys are ignored.
- Re-apply from EDIT after a RUN→EDIT return overwrites cfg_out and pulses apply_stb again.
- Field arithmetic is VAL_W bits wide. Any value above VAL_MAX is unreachable; reset and wrap only produce 0..VAL_MAX.
- Unused level encoding 3 recovers to TOP with the same clears as quit from EDIT.

## Timing
- Key pulse sampled at rising edge N. All resulting output changes are visible after edge N, i.e. one-cycle latency.
- apply_stb is high exactly during the cycle after the confirm edge. cfg_out and cfg_valid are already updated in that same cycle.
- menu_act changes in the same cycle as level.
- Back-to-back pulses on consecutive cycles are each acted on. There is no minimum spacing.
- Asynchronous reset mid-operation forces all reset values immediately. An in-flight apply_stb is cut. The first key pulse after deassertion is acted on normally.
- Key pulses wider than one cycle act once per high cycle. Single-cycle pulsing is the debouncer's responsibility.

## Test plan
- Reset, then 4×key_right in TOP (N_MENU=3) → menu_sel 1,2,0,1. Then key_left×2 → 0, then 2. level stays 0 and menu_act=0 throughout.
- menu_sel=1, then confirm → level=1, menu_act=3'b010, field_sel=0. Then key_left on field 0 → edit_vals[1:0]=3. Then key_right → 0.
- In EDIT: key_up from field 0 → field_sel=4 (apply row). key_right there → edit_vals unchanged. Set field 2 to 2, go to apply row, confirm → apply_stb one cycle, cfg_out[5:4]=2, cfg_valid=1, level=2.
- In RUN: key_left/right/up/down/confirm → no output change. quit → level=1 with edit_vals and cfg_out unchanged. quit again → level=0, cfg_valid=0, edit_vals=0, menu_sel retained.
- key_quit and key_confirm pulsed in the same cycle in EDIT on the apply row → quit wins: level=0, no apply_stb. key_up+key_down together → field_sel decrements only.
- Drive rst_n low for a fraction of a cycle in RUN, during the apply_stb cycle → all outputs go to reset values asynchronously. After release, key_right → menu_sel=1.

Source files
------------

// File: rtl/menu_nav_ctrl_if.sv
// Front-panel key pulses in, menu state and committed configuration out.
// master drives the keys (panel side); slave is the navigation controller.
interface menu_nav_ctrl_if #(
  parameter int unsigned N_MENU  = 3,
  parameter int unsigned N_FIELD = 4,
  parameter int unsigned VAL_W   = 2
);
  localparam int unsigned MSEL_W = (N_MENU > 1) ? $clog2(N_MENU) : 1;
  localparam int unsigned FSEL_W = $clog2(N_FIELD + 1);
  localparam int unsigned BANK_W = N_FIELD * VAL_W;

  logic              key_left;
  logic              key_right;
  logic              key_up;
  logic              key_down;
  logic              key_confirm;
  logic              key_quit;
  logic [1:0]        level;
  logic [MSEL_W-1:0] menu_sel;
  logic [N_MENU-1:0] menu_act;
  logic [FSEL_W-1:0] field_sel;
  logic [BANK_W-1:0] edit_vals;
  logic [BANK_W-1:0] cfg_out;
  logic              cfg_valid;
  logic              apply_stb;

  modport master (
    output key_left, key_right, key_up, key_down, key_confirm, key_quit,
    input  level, menu_sel, menu_act, field_sel, edit_vals, cfg_out, cfg_valid, apply_stb
  );

  modport slave (
    input  key_left, key_right, key_up, key_down, key_confirm, key_quit,
    output level, menu_sel, menu_act, field_sel, edit_vals, cfg_out, cfg_valid, apply_stb
  );
endinterface

// File: rtl/menu_nav_ctrl.sv
// Key-driven menu navigation: TOP item select, EDIT field bank, RUN with
// committed configuration. One key action per cycle, all outputs registered.
module menu_nav_ctrl #(
  parameter int unsigned N_MENU  = 3,
  parameter int unsigned N_FIELD = 4,
  parameter int unsigned VAL_W   = 2,
  parameter int unsigned VAL_MAX = 3
) (
  input  logic           clk_50M,
  input  logic           rst_n,
  menu_nav_ctrl_if.slave bus
);
  localparam int unsigned MSEL_W = (N_MENU > 1) ? $clog2(N_MENU) : 1;
  localparam int unsigned FSEL_W = $clog2(N_FIELD + 1);
  localparam int unsigned BANK_W = N_FIELD * VAL_W;

  typedef enum logic [1:0] {
    LVL_TOP  = 2'd0,
    LVL_EDIT = 2'd1,
    LVL_RUN  = 2'd2
  } level_e;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_QUIT,
    ACT_CONFIRM,
    ACT_UP,
    ACT_DOWN,
    ACT_LEFT,
    ACT_RIGHT
  } act_e;

  level_e            level_q,   level_d;
  logic [MSEL_W-1:0] sel_q,     sel_d;
  logic [N_MENU-1:0] mact_q,    mact_d;
  logic [FSEL_W-1:0] field_q,   field_d;
  logic [BANK_W-1:0] edit_q,    edit_d;
  logic [BANK_W-1:0] cfg_q,     cfg_d;
  logic              valid_q,   valid_d;
  logic              stb_q,     stb_d;
  act_e              act;

  function automatic logic [VAL_W-1:0] val_step(input logic [VAL_W-1:0] v, input logic inc);
    if (inc) return (v == VAL_W'(VAL_MAX)) ? '0 : v + VAL_W'(1);
    else     return (v == '0) ? VAL_W'(VAL_MAX) : v - VAL_W'(1);
  endfunction

  // Fixed-priority key arbitration; losers are dropped this cycle
  always_comb begin
    act = ACT_NONE;
    if      (bus.key_quit)    act = ACT_QUIT;
    else if (bus.key_confirm) act = ACT_CONFIRM;
    else if (bus.key_up)      act = ACT_UP;
    else if (bus.key_down)    act = ACT_DOWN;
    else if (bus.key_left)    act = ACT_LEFT;
    else if (bus.key_right)   act = ACT_RIGHT;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= LVL_TOP;
      sel_q   <= '0;
      mact_q  <= '0;
      field_q <= '0;
      edit_q  <= '0;
      cfg_q   <= '0;
      valid_q <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      sel_q   <= sel_d;
      mact_q  <= mact_d;
      field_q <= field_d;
      edit_q  <= edit_d;
      cfg_q   <= cfg_d;
      valid_q <= valid_d;
      stb_q   <= stb_d;
    end
  end

  always_comb begin
    level_d = level_q;
    sel_d   = sel_q;
    field_d = field_q;
    edit_d  = edit_q;
    cfg_d   = cfg_q;
    valid_d = valid_q;
    stb_d   = 1'b0;
    mact_d  = '0;

    case (level_q)
      LVL_TOP: begin
        case (act)
          ACT_CONFIRM: begin
            level_d = LVL_EDIT;
            field_d = '0;
          end
          ACT_LEFT:  sel_d = (sel_q == '0) ? MSEL_W'(N_MENU - 1) : sel_q - MSEL_W'(1);
          ACT_RIGHT: sel_d = (sel_q == MSEL_W'(N_MENU - 1)) ? '0 : sel_q + MSEL_W'(1);
          default: ;
        endcase
      end

      LVL_EDIT: begin
        case (act)
          ACT_QUIT: begin
            level_d = LVL_TOP;
            field_d = '0;
            edit_d  = '0;
            cfg_d   = '0;
            valid_d = 1'b0;
          end
          ACT_CONFIRM: begin
            if (field_q == FSEL_W'(N_FIELD)) begin
              level_d = LVL_RUN;
              cfg_d   = edit_q;
              valid_d = 1'b1;
              stb_d   = 1'b1;
            end
          end
          ACT_UP:   field_d = (field_q == '0) ? FSEL_W'(N_FIELD) : field_q - FSEL_W'(1);
          ACT_DOWN: field_d = (field_q == FSEL_W'(N_FIELD)) ? '0 : field_q + FSEL_W'(1);
          ACT_LEFT, ACT_RIGHT: begin
            // Apply row never matches a field index, so it is left untouched
            for (int i = 0; i < N_FIELD; i++) begin
              if (field_q == FSEL_W'(i))
                edit_d[i*VAL_W +: VAL_W] = val_step(edit_q[i*VAL_W +: VAL_W], act == ACT_RIGHT);
            end
          end
          default: ;
        endcase
      end

      LVL_RUN: begin
        if (act == ACT_QUIT) level_d = LVL_EDIT;
      end

      default: begin
        level_d = LVL_TOP;
        field_d = '0;
        edit_d  = '0;
        cfg_d   = '0;
        valid_d = 1'b0;
      end
    endcase

    if (level_d != LVL_TOP) mact_d = N_MENU'(1) << sel_d;
  end

  assign bus.level     = level_q;
  assign bus.menu_sel  = sel_q;
  assign bus.menu_act  = mact_q;
  assign bus.field_sel = field_q;
  assign bus.edit_vals = edit_q;
  assign bus.cfg_out   = cfg_q;
  assign bus.cfg_valid = valid_q;
  assign bus.apply_stb = stb_q;
endmodule

// File: tb/tb_menu_nav_ctrl.sv
// Bench for menu_nav_ctrl: directed vector table, corner sequences, and
// randomized key traffic against an array-based reference model.
module tb_menu_nav_ctrl;
  localparam int unsigned N_MENU  = 3;
  localparam int unsigned N_FIELD = 4;
  localparam int unsigned VAL_W   = 2;
  localparam int unsigned VAL_MAX = 3;
  localparam int unsigned MSEL_W  = 2;
  localparam int unsigned FSEL_W  = 3;
  localparam int unsigned EW      = N_FIELD * VAL_W;
  localparam int unsigned OW      = 2 + MSEL_W + N_MENU + FSEL_W + 2*EW + 2;

  // key vector order: {quit, confirm, up, down, left, right}
  localparam logic [5:0] K_R = 6'b000001;
  localparam logic [5:0] K_L = 6'b000010;
  localparam logic [5:0] K_D = 6'b000100;
  localparam logic [5:0] K_U = 6'b001000;
  localparam logic [5:0] K_C = 6'b010000;
  localparam logic [5:0] K_Q = 6'b100000;
  localparam logic [5:0] K_0 = 6'b000000;

  typedef struct {
    logic [5:0] keys;
    int lvl, sel, act, f, ev, cfg, v, stb;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  // reference model state
  int m_lvl, m_sel, m_f, m_valid, m_stb;
  int m_vals[N_FIELD];
  int m_cfg[N_FIELD];

  always #5 clk = ~clk;

  menu_nav_ctrl_if #(.N_MENU(N_MENU), .N_FIELD(N_FIELD), .VAL_W(VAL_W)) bus ();

  menu_nav_ctrl #(.N_MENU(N_MENU), .N_FIELD(N_FIELD), .VAL_W(VAL_W), .VAL_MAX(VAL_MAX)) dut (
    .clk_50M (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  function automatic logic [OW-1:0] pack(int lvl, int sel, int act, int f, int ev, int cfg, int v, int stb);
    return {2'(lvl), MSEL_W'(sel), N_MENU'(act), FSEL_W'(f), EW'(ev), EW'(cfg), 1'(v), 1'(stb)};
  endfunction

  function automatic logic [OW-1:0] obs();
    return {bus.level, bus.menu_sel, bus.menu_act, bus.field_sel, bus.edit_vals,
            bus.cfg_out, bus.cfg_valid, bus.apply_stb};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] exp);
    logic [OW-1:0] got;
    got = obs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got lvl=%0d sel=%0d act=%b fld=%0d ev=%h cfg=%h v=%b stb=%b, want lvl=%0d sel=%0d act=%b fld=%0d ev=%h cfg=%h v=%b stb=%b",
               name, got[OW-1 -: 2], got[OW-3 -: MSEL_W], got[OW-3-MSEL_W -: N_MENU],
               got[2*EW+2 +: FSEL_W], got[EW+2 +: EW], got[2 +: EW], got[1], got[0],
               exp[OW-1 -: 2], exp[OW-3 -: MSEL_W], exp[OW-3-MSEL_W -: N_MENU],
               exp[2*EW+2 +: FSEL_W], exp[EW+2 +: EW], exp[2 +: EW], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic [5:0] k);
    {bus.key_quit, bus.key_confirm, bus.key_up, bus.key_down, bus.key_left, bus.key_right} = k;
  endtask

  // one key cycle: drive at negedge, sample 1ns after the rising edge
  task automatic apply(input logic [5:0] k);
    @(negedge clk);
    drive(k);
    @(posedge clk);
    #1;
    drive(K_0);
  endtask

  task automatic add(input logic [5:0] k, input int lvl, sel, act, f, ev, cfg, v, stb);
    vec_t t;
    t.keys = k; t.lvl = lvl; t.sel = sel; t.act = act; t.f = f;
    t.ev = ev; t.cfg = cfg; t.v = v; t.stb = stb;
    vecs.push_back(t);
  endtask

  task automatic run_vec(input string name, input vec_t t);
    apply(t.keys);
    check(name, pack(t.lvl, t.sel, t.act, t.f, t.ev, t.cfg, t.v, t.stb));
  endtask

  task automatic model_reset();
    m_lvl = 0; m_sel = 0; m_f = 0; m_valid = 0; m_stb = 0;
    for (int i = 0; i < N_FIELD; i++) begin m_vals[i] = 0; m_cfg[i] = 0; end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    drive(K_0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Behavioural model: highest pressed key wins, indices wrap with modulo
  task automatic model_step(input logic [5:0] k);
    bit q, c, u, d, l, r;
    {q, c, u, d, l, r} = k;
    m_stb = 0;
    if (m_lvl == 0) begin
      if (q) ;
      else if (c) begin m_lvl = 1; m_f = 0; end
      else if (u || d) ;
      else if (l) m_sel = (m_sel + N_MENU - 1) % N_MENU;
      else if (r) m_sel = (m_sel + 1) % N_MENU;
    end else if (m_lvl == 1) begin
      if (q) begin
        m_lvl = 0; m_f = 0; m_valid = 0;
        for (int i = 0; i < N_FIELD; i++) begin m_vals[i] = 0; m_cfg[i] = 0; end
      end else if (c) begin
        if (m_f == N_FIELD) begin
          m_cfg = m_vals; m_valid = 1; m_stb = 1; m_lvl = 2;
        end
      end else if (u) m_f = (m_f + N_FIELD) % (N_FIELD + 1);
      else if (d) m_f = (m_f + 1) % (N_FIELD + 1);
      else if (l) begin
        if (m_f < N_FIELD) m_vals[m_f] = (m_vals[m_f] + VAL_MAX) % (VAL_MAX + 1);
      end else if (r) begin
        if (m_f < N_FIELD) m_vals[m_f] = (m_vals[m_f] + 1) % (VAL_MAX + 1);
      end
    end else begin
      if (q) m_lvl = 1;
    end
  endtask

  function automatic logic [OW-1:0] model_exp();
    int ev, cfg;
    ev = 0; cfg = 0;
    for (int i = 0; i < N_FIELD; i++) begin
      ev  += m_vals[i] * (1 << (i * VAL_W));
      cfg += m_cfg[i]  * (1 << (i * VAL_W));
    end
    return pack(m_lvl, m_sel, (m_lvl != 0) ? (1 << m_sel) : 0, m_f, ev, cfg, m_valid, m_stb);
  endfunction

  initial begin
    drive(K_0);
    // keys          lvl sel act f  ev     cfg    v  stb
    add(K_R,         0,  1,  0,  0, 'h00, 'h00, 0, 0);
    add(K_R,         0,  2,  0,  0, 'h00, 'h00, 0, 0);
    add(K_R,         0,  0,  0,  0, 'h00, 'h00, 0, 0);
    add(K_R,         0,  1,  0,  0, 'h00, 'h00, 0, 0);
    add(K_L,         0,  0,  0,  0, 'h00, 'h00, 0, 0);
    add(K_L,         0,  2,  0,  0, 'h00, 'h00, 0, 0);
    add(K_R,         0,  0,  0,  0, 'h00, 'h00, 0, 0);
    add(K_R,         0,  1,  0,  0, 'h00, 'h00, 0, 0);
    add(K_U|K_D,     0,  1,  0,  0, 'h00, 'h00, 0, 0);
    add(K_C,         1,  1,  2,  0, 'h00, 'h00, 0, 0);
    add(K_L,         1,  1,  2,  0, 'h03, 'h00, 0, 0);
    add(K_R,         1,  1,  2,  0, 'h00, 'h00, 0, 0);
    add(K_U,         1,  1,  2,  4, 'h00, 'h00, 0, 0);
    add(K_R,         1,  1,  2,  4, 'h00, 'h00, 0, 0);
    add(K_U,         1,  1,  2,  3, 'h00, 'h00, 0, 0);
    add(K_U,         1,  1,  2,  2, 'h00, 'h00, 0, 0);
    add(K_R,         1,  1,  2,  2, 'h10, 'h00, 0, 0);
    add(K_R,         1,  1,  2,  2, 'h20, 'h00, 0, 0);
    add(K_C,         1,  1,  2,  2, 'h20, 'h00, 0, 0);
    add(K_D,         1,  1,  2,  3, 'h20, 'h00, 0, 0);
    add(K_D,         1,  1,  2,  4, 'h20, 'h00, 0, 0);
    add(K_C,         2,  1,  2,  4, 'h20, 'h20, 1, 1);
    add(K_L,         2,  1,  2,  4, 'h20, 'h20, 1, 0);
    add(K_R,         2,  1,  2,  4, 'h20, 'h20, 1, 0);
    add(K_U,         2,  1,  2,  4, 'h20, 'h20, 1, 0);
    add(K_D,         2,  1,  2,  4, 'h20, 'h20, 1, 0);
    add(K_C,         2,  1,  2,  4, 'h20, 'h20, 1, 0);
    add(K_Q,         1,  1,  2,  4, 'h20, 'h20, 1, 0);
    add(K_Q,         0,  1,  0,  0, 'h00, 'h00, 0, 0);
    add(K_C,         1,  1,  2,  0, 'h00, 'h00, 0, 0);
    add(K_D,         1,  1,  2,  1, 'h00, 'h00, 0, 0);
    add(K_D,         1,  1,  2,  2, 'h00, 'h00, 0, 0);
    add(K_D,         1,  1,  2,  3, 'h00, 'h00, 0, 0);
    add(K_D,         1,  1,  2,  4, 'h00, 'h00, 0, 0);
    add(K_Q|K_C,     0,  1,  0,  0, 'h00, 'h00, 0, 0);
    add(K_C,         1,  1,  2,  0, 'h00, 'h00, 0, 0);
    add(K_U|K_D,     1,  1,  2,  4, 'h00, 'h00, 0, 0);
    add(K_U|K_D,     1,  1,  2,  3, 'h00, 'h00, 0, 0);
    add(K_L|K_R,     1,  1,  2,  3, 'hC0, 'h00, 0, 0);
    add(K_0,         1,  1,  2,  3, 'hC0, 'h00, 0, 0);

    reset_dut();
    #1;
    check("reset", pack(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // re-apply after RUN->EDIT overwrites cfg and pulses again
    reset_dut();
    apply(K_C);
    apply(K_U);
    apply(K_C);
    check("apply0", pack(2, 0, 1, 4, 0, 0, 1, 1));
    apply(K_Q);
    apply(K_U);
    apply(K_R);
    apply(K_D);
    apply(K_C);
    check("reapply", pack(2, 0, 1, 4, 'h40, 'h40, 1, 1));
    apply(K_0);
    check("reapply_stb_drop", pack(2, 0, 1, 4, 'h40, 'h40, 1, 0));

    // async reset during the apply strobe cycle
    apply(K_Q);
    apply(K_C);
    check("stb_before_rst", pack(2, 0, 1, 4, 'h40, 'h40, 1, 1));
    #1 rst_n = 1'b0;
    #1 check("async_rst", pack(0, 0, 0, 0, 0, 0, 0, 0));
    #1 rst_n = 1'b1;
    apply(K_R);
    check("post_rst_key", pack(0, 1, 0, 0, 0, 0, 0, 0));

    // randomized traffic against the model
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] k;
      k[0] = ($urandom_range(0, 3) == 0);
      k[1] = ($urandom_range(0, 3) == 0);
      k[2] = ($urandom_range(0, 3) == 0);
      k[3] = ($urandom_range(0, 4) == 0);
      k[4] = ($urandom_range(0, 4) == 0);
      k[5] = ($urandom_range(0, 14) == 0);
      apply(k);
      model_step(k);
      check($sformatf("rand%0d", n), model_exp());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
